// File: rtl/muldiv_pkg.sv
// Shared types, constants and sign decode for the multiply/divide sequencing controller.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OpMul  = 2'b00,
    OpMulh = 2'b01,
    OpDiv  = 2'b10,
    OpRem  = 2'b11
  } operator_t;

  // Bit 1: operand a signed, bit 0: operand b signed.
  typedef enum logic [1:0] {
    ModeUU = 2'b00,
    ModeSU = 2'b10,
    ModeSS = 2'b11
  } sign_mode_t;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Dividend and divisor of the only signed-overflowing divide, at 32 bits.
  localparam logic [31:0] OVERFLOW_END = 32'h8000_0000;
  localparam logic [31:0] OVERFLOW_SOR = 32'hFFFF_FFFF;

  // Maps op[3:0] to the unit's signed mode; divides only know fully signed or unsigned.
  function automatic sign_mode_t decode_sign(input logic [3:0] op);
    sign_mode_t mode;
    mode = ModeUU;
    if (op[3]) begin
      if (op[1:0] == 2'd1) mode = ModeSS;
    end else begin
      case (op[1:0])
        2'd1:    mode = ModeSS;
        2'd2:    mode = ModeSU;
        default: mode = ModeUU;
      endcase
    end
    return mode;
  endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Detects divides the unit must not run (divide by zero, signed overflow) and their results.
module muldiv_special_case
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            is_special_o,
  output logic [XLEN-1:0] special_res_o
);

  // Widen the 32-bit reference constants to XLEN (XLEN >= 32).
  localparam logic [XLEN-1:0] OvfEnd = XLEN'(OVERFLOW_END) << (XLEN - 32);
  localparam logic [XLEN-1:0] OvfSor = XLEN'($signed(OVERFLOW_SOR));

  logic is_div, is_rem, div_zero, overflow;

  assign is_div   = op_i[3];
  assign is_rem   = op_i[2];
  assign div_zero = is_div & (b_i == '0);
  assign overflow = is_div & (decode_sign(op_i) == ModeSS) & (a_i == OvfEnd) & (b_i == OvfSor);

  // Divide by zero takes priority; the two cases are disjoint anyway since OvfSor != 0.
  always_comb begin
    is_special_o  = div_zero | overflow;
    special_res_o = '0;
    if (div_zero) begin
      special_res_o = is_rem ? a_i : '1;
    end else if (overflow) begin
      special_res_o = is_rem ? '0 : OvfEnd;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences one multiply/divide request at a time through the multi-cycle unit.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o,
  output logic [1:0]      unit_operator_o,
  output logic [1:0]      unit_signed_mode_o,
  output logic [XLEN-1:0] unit_a_o,
  output logic [XLEN-1:0] unit_b_o,
  output logic            unit_start_o,
  input  logic [XLEN-1:0] unit_result_i
);

  localparam int unsigned CntW = $clog2(DIV_LAT + 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  operator_t       oper_q, oper_d;
  sign_mode_t      mode_q, mode_d;
  logic            start_q, start_d;

  logic            accept, is_noop, is_special;
  logic [XLEN-1:0] special_res;
  logic [CntW-1:0] lat_sel;

  muldiv_special_case #(
    .XLEN(XLEN)
  ) u_special (
    .op_i         (op_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .is_special_o (is_special),
    .special_res_o(special_res)
  );

  assign accept  = req_valid_i & req_ready_o;
  assign is_noop = (op_i == 4'b0000);
  assign lat_sel = op_i[3] ? CntW'(DIV_LAT) : CntW'(MUL_LAT);

  // Next-state: accept in IDLE, count down in RUN, hold the response in DONE; flush wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    oper_d  = oper_q;
    mode_d  = mode_q;
    start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d    = a_i;
          b_d    = b_i;
          oper_d = operator_t'(op_i[3:2]);
          mode_d = decode_sign(op_i);
          if (is_noop) begin
            res_d   = '0;
            state_d = StDone;
          end else if (is_special) begin
            res_d   = special_res;
            state_d = StDone;
          end else begin
            cnt_d   = lat_sel;
            start_d = 1'b1;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          res_d   = unit_result_i;
          state_d = StDone;
        end
      end
      StDone: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A result landing in the flush cycle is dropped along with the operation.
    if (flush_i) begin
      state_d = StIdle;
      res_d   = res_q;
      start_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      oper_q  <= OpMul;
      mode_q  <= ModeUU;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      oper_q  <= oper_d;
      mode_q  <= mode_d;
      start_q <= start_d;
    end
  end

  assign req_ready_o        = (state_q == StIdle) & ~flush_i;
  assign rsp_valid_o        = (state_q == StDone);
  assign busy_o             = (state_q != StIdle);
  assign res_o              = res_q;
  assign unit_operator_o    = oper_q;
  assign unit_signed_mode_o = mode_q;
  assign unit_a_o           = a_q;
  assign unit_b_o           = b_q;
  assign unit_start_o       = start_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with a timed unit model and an arithmetic reference.
module tb_muldiv_ctrl;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [3:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] res_o;
  logic        busy_o;
  logic [1:0]  unit_operator_o, unit_signed_mode_o;
  logic [31:0] unit_a_o, unit_b_o;
  logic        unit_start_o;
  logic [31:0] unit_result_i;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .XLEN   (XLEN),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .op_i              (op_i),
    .a_i               (a_i),
    .b_i               (b_i),
    .flush_i           (flush_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .res_o             (res_o),
    .busy_o            (busy_o),
    .unit_operator_o   (unit_operator_o),
    .unit_signed_mode_o(unit_signed_mode_o),
    .unit_a_o          (unit_a_o),
    .unit_b_o          (unit_b_o),
    .unit_start_o      (unit_start_o),
    .unit_result_i     (unit_result_i)
  );

  // Unit model: computes from its control inputs; mode bit1 = a signed, bit0 = b signed.
  function automatic logic [31:0] unit_calc(input logic [1:0] oper, input logic [1:0] mode,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic signed [31:0] sq;
    ea = mode[1] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = mode[0] ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    if (oper == 2'd0) return p[31:0];
    if (oper == 2'd1) return p[63:32];
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 32'hBAD1_BAD1;
    if (mode == 2'b11) begin
      sq = (oper == 2'd2) ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
      return sq;
    end
    return (oper == 2'd2) ? a / b : a % b;
  endfunction

  // Result is only valid in the cycle the controller should sample it; junk otherwise.
  int unsigned since_start = 0;
  always @(posedge clk) begin
    if (unit_start_o) since_start <= 1;
    else if (since_start != 0) since_start <= since_start + 1;
  end
  always @* begin
    if (since_start == ((unit_operator_o[1] ? DIV_LAT : MUL_LAT) - 1))
      unit_result_i = unit_calc(unit_operator_o, unit_signed_mode_o, unit_a_o, unit_b_o);
    else
      unit_result_i = 32'hBAD0_0BAD;
  end

  // Reference result straight from the op encoding rules.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic sa, sb, sgn;
    logic signed [31:0] sq;
    if (op == 4'd0) return 32'd0;
    if (!op[3]) begin
      sa = (op[1:0] == 2'd1) || (op[1:0] == 2'd2);
      sb = (op[1:0] == 2'd1);
      ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return op[2] ? p[63:32] : p[31:0];
    end
    sgn = (op[1:0] == 2'd1);
    if (b == 32'd0) return op[2] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[2] ? 32'd0 : 32'h8000_0000;
    if (sgn) begin
      sq = op[2] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      return sq;
    end
    return op[2] ? a % b : a / b;
  endfunction

  function automatic bit is_shortcut(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    return (op == 4'd0) || (op[3] && (b == 32'd0 ||
           (op[1:0] == 2'd1 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)));
  endfunction

  // Drives one transaction from a negedge; returns cycle offsets relative to the accept cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int rsp_cyc, output int starts,
                        output int start_cyc);
    int wait_c;
    starts = 0; start_cyc = -1; rsp_cyc = -1; res = 32'hxxxx_xxxx; wait_c = 0;
    while (!req_ready_o && wait_c < 100) begin
      @(negedge clk);
      wait_c++;
    end
    req_valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    req_valid_i = 1'b0; op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
    for (int k = 1; k <= 100; k++) begin
      if (unit_start_o) begin
        starts++;
        start_cyc = k;
      end
      if (rsp_valid_o) begin
        rsp_cyc = k;
        res = res_o;
        break;
      end
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    flush_i = 1'b0; rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); else n_pass++;
    n_total++; if (unit_start_o !== 1'b0) $display("FAIL reset_start: got %b want 0", unit_start_o); else n_pass++;
    n_total++; if (res_o !== 32'd0) $display("FAIL reset_res: got %h want 0", res_o); else n_pass++;
    n_total++; if ({unit_operator_o, unit_signed_mode_o} !== 4'd0)
      $display("FAIL reset_unit_ctl: got %b want 0000", {unit_operator_o, unit_signed_mode_o}); else n_pass++;
    n_total++; if ({unit_a_o, unit_b_o} !== 64'd0)
      $display("FAIL reset_unit_ops: got %h want 0", {unit_a_o, unit_b_o}); else n_pass++;
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready_o); else n_pass++;
  endtask

  task automatic test_mul;
    logic [31:0] res; int rc, st, sc;
    run_op(4'b0001, 32'd7, 32'hFFFF_FFFD, res, rc, st, sc);
    n_total++; if (unit_operator_o !== 2'b00) $display("FAIL mul_operator: got %b want 00", unit_operator_o); else n_pass++;
    n_total++; if (unit_signed_mode_o !== 2'b11) $display("FAIL mul_mode: got %b want 11", unit_signed_mode_o); else n_pass++;
    n_total++; if (st !== 1 || sc !== 1) $display("FAIL mul_start: got %0d pulses at +%0d want 1 at +1", st, sc); else n_pass++;
    n_total++; if (rc !== MUL_LAT + 1) $display("FAIL mul_latency: got +%0d want +%0d", rc, MUL_LAT + 1); else n_pass++;
    n_total++; if (res !== 32'hFFFF_FFEB) $display("FAIL mul_result: got %h want ffffffeb", res); else n_pass++;
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL mul_ready_after: got %b want 1", req_ready_o); else n_pass++;
  endtask

  task automatic test_div_special;
    logic [3:0]  ops [4] = '{4'b1000, 4'b1101, 4'b1001, 4'b1101};
    logic [31:0] as  [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'd0};
    logic [31:0] res; int rc, st, sc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, rc, st, sc);
      n_total++; if (res !== exp[i]) $display("FAIL special%0d_result: got %h want %h", i, res, exp[i]); else n_pass++;
      n_total++; if (st !== 0) $display("FAIL special%0d_start: got %0d pulses want 0", i, st); else n_pass++;
      n_total++; if (rc !== 1) $display("FAIL special%0d_latency: got +%0d want +1", i, rc); else n_pass++;
    end
  endtask

  task automatic test_flush;
    logic [31:0] a, b, res, exp; int rc, st, sc; bit saw_rsp, saw_start;
    a = {1'b0, 31'($urandom)}; b = $urandom | 32'd1;
    req_valid_i = 1'b1; op_i = 4'b1001; a_i = a; b_i = b;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    n_total++; if (busy_o !== 1'b1) $display("FAIL flush_busy_before: got %b want 1", busy_o); else n_pass++;
    flush_i = 1'b1; req_valid_i = 1'b1; op_i = 4'b0001; a_i = 32'd5; b_i = 32'd6;
    #1;
    n_total++; if (req_ready_o !== 1'b0) $display("FAIL flush_ready: got %b want 0", req_ready_o); else n_pass++;
    @(negedge clk);
    flush_i = 1'b0; req_valid_i = 1'b0;
    #1;
    n_total++; if (busy_o !== 1'b0) $display("FAIL flush_idle: got busy %b want 0", busy_o); else n_pass++;
    n_total++; if (unit_start_o !== 1'b0) $display("FAIL flush_not_accepted: got start %b want 0", unit_start_o); else n_pass++;
    saw_rsp = 1'b0; saw_start = 1'b0;
    repeat (40) begin
      if (rsp_valid_o) saw_rsp = 1'b1;
      if (unit_start_o) saw_start = 1'b1;
      @(negedge clk);
    end
    n_total++; if (saw_rsp || saw_start)
      $display("FAIL flush_silent: got rsp %b start %b want 0 0", saw_rsp, saw_start); else n_pass++;
    a = $urandom; b = $urandom;
    exp = ref_result(4'b0101, a, b);
    run_op(4'b0101, a, b, res, rc, st, sc);
    n_total++; if (res !== exp || rc !== MUL_LAT + 1)
      $display("FAIL flush_next_mul: got %h at +%0d want %h at +%0d", res, rc, exp, MUL_LAT + 1); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [3:0] op; logic [31:0] a, b, exp, held; int waited; bit bad_stable, bad_ready;
    op = {2'b01, 2'($urandom)}; a = $urandom; b = $urandom;
    exp = ref_result(op, a, b);
    req_valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    req_valid_i = 1'b0;
    waited = 0;
    while (!rsp_valid_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_total++; if (rsp_valid_o !== 1'b1 || res_o !== exp)
      $display("FAIL bp_result: got valid %b res %h want 1 %h", rsp_valid_o, res_o, exp); else n_pass++;
    held = res_o; bad_stable = 1'b0; bad_ready = 1'b0;
    req_valid_i = 1'b1; op_i = 4'b0000; a_i = $urandom; b_i = $urandom;
    repeat (5) begin
      @(negedge clk);
      if (res_o !== held || rsp_valid_o !== 1'b1) bad_stable = 1'b1;
      if (req_ready_o !== 1'b0) bad_ready = 1'b1;
    end
    n_total++; if (bad_stable) $display("FAIL bp_stable: got changed res/valid want held %h", held); else n_pass++;
    n_total++; if (bad_ready) $display("FAIL bp_ready: got ready 1 want 0"); else n_pass++;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    n_total++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0)
      $display("FAIL bp_release: got ready %b valid %b want 1 0", req_ready_o, rsp_valid_o); else n_pass++;
    @(negedge clk);
    req_valid_i = 1'b0;
    n_total++; if (rsp_valid_o !== 1'b1 || res_o !== 32'd0)
      $display("FAIL bp_noop: got valid %b res %h want 1 00000000", rsp_valid_o, res_o); else n_pass++;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0] op; logic [31:0] a, b, res, exp; int rc, st, sc, sel, lat; bit sc_op;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op = 4'($urandom); a = $urandom; b = $urandom;
      if (sel == 0) op = 4'b0000;
      if (sel == 1) begin
        op[3] = 1'b1;
        b = 32'd0;
      end
      if (sel == 2) begin
        op = {1'b1, op[2], 2'b01};
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      sc_op = is_shortcut(op, a, b);
      exp = ref_result(op, a, b);
      lat = sc_op ? 1 : ((op[3] ? DIV_LAT : MUL_LAT) + 1);
      run_op(op, a, b, res, rc, st, sc);
      n_total++; if (res !== exp)
        $display("FAIL rand%0d_result op=%b a=%h b=%h: got %h want %h", i, op, a, b, res, exp); else n_pass++;
      n_total++; if (rc !== lat) $display("FAIL rand%0d_latency op=%b: got +%0d want +%0d", i, op, rc, lat); else n_pass++;
      n_total++; if (st !== (sc_op ? 0 : 1))
        $display("FAIL rand%0d_start op=%b: got %0d pulses want %0d", i, op, st, sc_op ? 0 : 1); else n_pass++;
      n_total++; if (req_ready_o !== 1'b1) $display("FAIL rand%0d_ready_after: got %b want 1", i, req_ready_o); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    req_valid_i = 1'b1; op_i = 4'b1010; a_i = $urandom; b_i = $urandom | 32'd1;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0)
      $display("FAIL rstmid_state: got busy %b valid %b want 0 0", busy_o, rsp_valid_o); else n_pass++;
    n_total++; if ({unit_a_o, unit_b_o, unit_operator_o, unit_signed_mode_o} !== 68'd0)
      $display("FAIL rstmid_regs: got %h want 0", {unit_a_o, unit_b_o, unit_operator_o, unit_signed_mode_o}); else n_pass++;
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", req_ready_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_special();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
